voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Schedules the fixed pool of synth voices among incoming MIDI key events.
- Sits between the MIDI serial receiver (ready pulse + 7-bit key index) and the oscillator bank.
- Each key event toggles a note: a key already sounding is released; a new key gets a free voice, or steals the oldest voice when none is free.
- Drives per-voice key, gate and retrigger outputs to the oscillators.

Parameters:
- NUM_VOICES, 4, number of voices in the pool (2..16).
- KEY_WIDTH, 7, key index width.
- AGE_WIDTH, 4, per-voice age counter width; saturates at 2^AGE_WIDTH-1.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle pulse: key event present (MIDI receiver ready).
- key_index  input  KEY_WIDTH  key of event, sampled when key_valid=1 and in_ready=1.
- in_ready  output  1  allocator idle, can accept an event.
- voice_key  output  NUM_VOICES*KEY_WIDTH  key per voice; voice v occupies bits [v*KEY_WIDTH +: KEY_WIDTH].
- voice_on  output  NUM_VOICES  gate per voice.
- voice_trigger  output  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.
- steal  output  1  one-cycle pulse, coincident with voice_trigger, when an active voice was stolen.
- drop_count  output  8  saturating count of key_valid pulses ignored while in_ready=0.

Behaviour:
- Reset (async, any state):
  - State=IDLE, in_ready=1.
  - voice_key=0, voice_on=0, voice_trigger=0, steal=0, drop_count=0, all ages=0.
- States are IDLE, SCAN, UPDATE.
- IDLE:
  - in_ready=1.
  - key_valid=1 latches key_index, clears scan registers, and moves to SCAN with scan index 0.
- SCAN: one voice examined per cycle, index 0..NUM_VOICES-1, in_ready=0. For voice i:
  - Match: voice_on[i]=1 and voice_key[i]==latched key; record the first match.
  - Free: voice_on[i]=0; record the lowest free index.
  - Oldest: the active voice with the largest age; ties go to the lower index.
  - After index NUM_VOICES-1, go to UPDATE.
- UPDATE (single cycle, in_ready=0), one action in priority order:
  - Match found: release it. voice_on[m]=0, voice_key[m] holds, no trigger, ages unchanged.
  - Else free voice found: assign it. voice_key[f]=key, voice_on[f]=1, age[f]=0, voice_trigger[f]=1 next cycle.
  - Else steal the oldest voice o. voice_key[o]=key, age[o]=0, voice_trigger[o]=1, steal=1; voice_on[o] stays 1.
  - On any assignment, every other active voice's age increments, saturating.
  - Then return to IDLE.
- Latency:
  - Event accepted at cycle T; SCAN covers T+1..T+NUM_VOICES; UPDATE at T+NUM_VOICES+1.
  - Outputs and pulses are visible at T+NUM_VOICES+2; in_ready=1 again that cycle.
  - With the default, an event is accepted at most once every 6 cycles.
  - This is far faster than the MIDI byte rate.
- key_valid while in_ready=0:
  - The event is ignored and drop_count increments, saturating at 255.
  - The latched key is not disturbed.
- key_valid exactly on the cycle in_ready returns to 1 is accepted.
- voice_trigger and steal are high for exactly one cycle and otherwise 0.
- Voices are never released except by a matching toggle or by reset. Ages of inactive voices are don't-care and are reset to 0 on assignment.
- Reset asserted mid-SCAN or mid-UPDATE aborts the event: no partial update, all voices off.

Test Plan:
- Reset, then keys 60, 62, 64 spaced 10 cycles apart → voices 0/1/2 get 60/62/64 with on=1; each voice_trigger pulses exactly 6 cycles after its accept cycle; steal=0 throughout.
- Keys 60, 62, then 60 again → voice 0 on=0 with key still 60; voice 1 unchanged; no trigger on the third event. A following key 67 → assigned to voice 0 (lowest free).
- Keys 60, 62, 64, 65, 67 → 67 steals voice 0 (age 3, oldest): voice_key[0]=67, trigger[0]=1, steal=1; other voice_on unchanged.
- A key_valid pulse 2 cycles after an accepted event → ignored, drop_count=1; after 300 such drops, drop_count=255.
- Reset asserted during SCAN of key 70 → all outputs 0 immediately; no trigger after release; next key 70 → voice 0.
- Tie on age (all 4 voices assigned, then 2 released and reassigned) → steal picks the lowest index among the maximum-age voices.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns a fixed pool of synth voices to incoming MIDI key events.
// Each accepted key toggles a note. If the key is already sounding, its voice is released.
// Otherwise the key gets the lowest free voice. If no voice is free, the oldest active
// voice is stolen.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   key_valid      one-cycle key event pulse from the MIDI receiver
//   key_index      key of the event, sampled when key_valid && in_ready
//   in_ready       allocator idle, next event can be accepted
//   voice_key      per-voice key, voice v at [v*KEY_WIDTH +: KEY_WIDTH]
//   voice_on       per-voice gate
//   voice_trigger  per-voice one-cycle (re)assignment pulse
//   steal          one-cycle pulse alongside voice_trigger when an active voice was taken
//   drop_count     saturating count of events ignored while busy
module voice_allocator #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned KEY_WIDTH  = 7,
   parameter int unsigned AGE_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             key_valid,
   input  logic [KEY_WIDTH-1:0]             key_index,
   output logic                             in_ready,
   output logic [NUM_VOICES*KEY_WIDTH-1:0]  voice_key,
   output logic [NUM_VOICES-1:0]            voice_on,
   output logic [NUM_VOICES-1:0]            voice_trigger,
   output logic                             steal,
   output logic [7:0]                       drop_count
);

   localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);

   typedef enum logic [1:0] {StIdle, StScan, StUpdate} state_e;

   state_e                state_q, state_d;
   logic [KEY_WIDTH-1:0]  key_q, key_d;
   logic [IdxW-1:0]       idx_q, idx_d;

   // Scan results collected over the SCAN pass
   logic                  match_found_q, match_found_d;
   logic [IdxW-1:0]       match_idx_q, match_idx_d;
   logic                  free_found_q, free_found_d;
   logic [IdxW-1:0]       free_idx_q, free_idx_d;
   logic                  old_found_q, old_found_d;
   logic [IdxW-1:0]       old_idx_q, old_idx_d;
   logic [AGE_WIDTH-1:0]  old_age_q, old_age_d;

   logic [KEY_WIDTH-1:0]  vkey_q [NUM_VOICES];
   logic [KEY_WIDTH-1:0]  vkey_d [NUM_VOICES];
   logic [AGE_WIDTH-1:0]  age_q  [NUM_VOICES];
   logic [AGE_WIDTH-1:0]  age_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] on_q, on_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic                  steal_q, steal_d;
   logic [7:0]            drop_q, drop_d;

   // Voice receiving the new key when no match was found
   logic [IdxW-1:0]       tgt;
   assign tgt = free_found_q ? free_idx_q : old_idx_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         key_q         <= '0;
         idx_q         <= '0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         old_found_q   <= 1'b0;
         old_idx_q     <= '0;
         old_age_q     <= '0;
         on_q          <= '0;
         trig_q        <= '0;
         steal_q       <= 1'b0;
         drop_q        <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            vkey_q[v] <= '0;
            age_q[v]  <= '0;
         end
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         idx_q         <= idx_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         old_found_q   <= old_found_d;
         old_idx_q     <= old_idx_d;
         old_age_q     <= old_age_d;
         on_q          <= on_d;
         trig_q        <= trig_d;
         steal_q       <= steal_d;
         drop_q        <= drop_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            vkey_q[v] <= vkey_d[v];
            age_q[v]  <= age_d[v];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      idx_d         = idx_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      free_found_d  = free_found_q;
      free_idx_d    = free_idx_q;
      old_found_d   = old_found_q;
      old_idx_d     = old_idx_q;
      old_age_d     = old_age_q;
      on_d          = on_q;
      trig_d        = '0;
      steal_d       = 1'b0;
      drop_d        = drop_q;
      in_ready      = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         vkey_d[v] = vkey_q[v];
         age_d[v]  = age_q[v];
      end

      if (key_valid && (state_q != StIdle) && (drop_q != 8'hff)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (key_valid) begin
               key_d         = key_index;
               idx_d         = '0;
               match_found_d = 1'b0;
               match_idx_d   = '0;
               free_found_d  = 1'b0;
               free_idx_d    = '0;
               old_found_d   = 1'b0;
               old_idx_d     = '0;
               old_age_d     = '0;
               state_d       = StScan;
            end
         end

         StScan: begin
            if (on_q[idx_q]) begin
               if (!match_found_q && (vkey_q[idx_q] == key_q)) begin
                  match_found_d = 1'b1;
                  match_idx_d   = idx_q;
               end
               // Strict compare keeps the lower index on equal ages
               if (!old_found_q || (age_q[idx_q] > old_age_q)) begin
                  old_found_d = 1'b1;
                  old_idx_d   = idx_q;
                  old_age_d   = age_q[idx_q];
               end
            end else if (!free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end
            if (idx_q == LastIdx) begin
               state_d = StUpdate;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         StUpdate: begin
            state_d = StIdle;
            if (match_found_q) begin
               on_d[match_idx_q] = 1'b0;
            end else begin
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (on_q[v] && (IdxW'(v) != tgt) && (age_q[v] != '1)) begin
                     age_d[v] = age_q[v] + 1'b1;
                  end
               end
               vkey_d[tgt] = key_q;
               age_d[tgt]  = '0;
               on_d[tgt]   = 1'b1;
               trig_d[tgt] = 1'b1;
               steal_d     = !free_found_q;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      voice_key = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_key[v*KEY_WIDTH +: KEY_WIDTH] = vkey_q[v];
      end
   end

   assign voice_on      = on_q;
   assign voice_trigger = trig_q;
   assign steal         = steal_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with hand-computed expectations (4 voices, 7-bit keys).
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        key_valid = 1'b0;
   logic [6:0]  key_index = '0;
   logic        in_ready;
   logic [27:0] voice_key;
   logic [3:0]  voice_on;
   logic [3:0]  voice_trigger;
   logic        steal;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] trig_seen;

   voice_allocator #(
      .NUM_VOICES(4),
      .KEY_WIDTH (7),
      .AGE_WIDTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_valid    (key_valid),
      .key_index    (key_index),
      .in_ready     (in_ready),
      .voice_key    (voice_key),
      .voice_on     (voice_on),
      .voice_trigger(voice_trigger),
      .steal        (steal),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [6:0] vk(input int v);
      return voice_key[v*7 +: 7];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Present a key for one cycle; returns at the negedge after the accepting edge.
   task automatic send(input logic [6:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_index = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   // Unchecked event, used to set up voice ages.
   task automatic play(input logic [6:0] k);
      send(k);
      repeat (7) @(negedge clk);
   endtask

   // Event with latency/pulse checks: trigger must appear 6 cycles after the accept cycle.
   task automatic ev(input string tag, input logic [6:0] k, input logic [3:0] exp_trig,
                     input logic exp_steal);
      send(k);
      repeat (4) @(negedge clk);
      check({tag, "_early_trig"}, voice_trigger, 4'b0000);
      check({tag, "_busy"}, in_ready, 1'b0);
      @(negedge clk);
      check({tag, "_trig"}, voice_trigger, exp_trig);
      check({tag, "_steal"}, steal, exp_steal);
      check({tag, "_ready"}, in_ready, 1'b1);
      @(negedge clk);
      check({tag, "_trig_off"}, {voice_trigger, steal}, 5'b0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_ready", in_ready, 1'b1);
      check("rst_on", voice_on, 4'b0000);
      check("rst_key", voice_key, 28'd0);
      check("rst_pulses", {voice_trigger, steal}, 5'b0);
      check("rst_drop", drop_count, 8'd0);
      reset = 1'b0;

      // Three keys into voices 0/1/2
      ev("a60", 7'd60, 4'b0001, 1'b0);
      ev("a62", 7'd62, 4'b0010, 1'b0);
      ev("a64", 7'd64, 4'b0100, 1'b0);
      check("a_on", voice_on, 4'b0111);
      check("a_k0", vk(0), 7'd60);
      check("a_k1", vk(1), 7'd62);
      check("a_k2", vk(2), 7'd64);

      // Toggle-off, then lowest-free reuse
      do_reset();
      ev("b60", 7'd60, 4'b0001, 1'b0);
      ev("b62", 7'd62, 4'b0010, 1'b0);
      ev("b60r", 7'd60, 4'b0000, 1'b0);
      check("b_on", voice_on, 4'b0010);
      check("b_k0_held", vk(0), 7'd60);
      check("b_k1", vk(1), 7'd62);
      ev("b67", 7'd67, 4'b0001, 1'b0);
      check("b_k0_new", vk(0), 7'd67);
      check("b_on2", voice_on, 4'b0011);

      // Steal oldest: ages 3,2,1,0 -> voice 0
      do_reset();
      ev("c60", 7'd60, 4'b0001, 1'b0);
      ev("c62", 7'd62, 4'b0010, 1'b0);
      ev("c64", 7'd64, 4'b0100, 1'b0);
      ev("c65", 7'd65, 4'b1000, 1'b0);
      ev("c67", 7'd67, 4'b0001, 1'b1);
      check("c_k0", vk(0), 7'd67);
      check("c_on", voice_on, 4'b1111);
      check("c_k3", vk(3), 7'd65);

      // Drops while busy
      do_reset();
      send(7'd70);
      @(negedge clk);
      key_valid = 1'b1;
      key_index = 7'd99;
      @(negedge clk);
      key_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("d_trig", voice_trigger, 4'b0001);
      check("d_k0", vk(0), 7'd70);
      check("d_drop1", drop_count, 8'd1);
      repeat (4) @(negedge clk);
      // Held key_valid from idle: accepts at cycles 0 and 6, drops the 10 between
      @(negedge clk);
      key_valid = 1'b1;
      key_index = 7'd99;
      repeat (12) @(negedge clk);
      check("d_drop11", drop_count, 8'd11);
      repeat (400) @(negedge clk);
      key_valid = 1'b0;
      check("d_drop_sat", drop_count, 8'd255);
      repeat (10) @(negedge clk);
      check("d_drop_hold", drop_count, 8'd255);

      // Reset mid-SCAN aborts the event
      do_reset();
      ev("e60", 7'd60, 4'b0001, 1'b0);
      send(7'd70);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("e_on", voice_on, 4'b0000);
      check("e_key", voice_key, 28'd0);
      check("e_ready", in_ready, 1'b1);
      check("e_drop", drop_count, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      trig_seen = '0;
      repeat (8) begin
         @(negedge clk);
         trig_seen = trig_seen | voice_trigger;
      end
      check("e_no_trig", trig_seen, 4'b0000);
      ev("e70", 7'd70, 4'b0001, 1'b0);
      check("e_k0", vk(0), 7'd70);

      // Age tie: voices 1 and 2 both saturate at 15 while voice 0 is reused
      do_reset();
      play(7'd60);
      play(7'd62);
      play(7'd64);
      play(7'd60);                  // release voice 0
      repeat (14) begin
         play(7'd80);
         play(7'd80);
      end
      play(7'd80);                  // voice 0 active, ages v0=0 v1=15 v2=15
      ev("f90", 7'd90, 4'b1000, 1'b0);
      ev("f91", 7'd91, 4'b0010, 1'b1);
      check("f_k1", vk(1), 7'd91);
      check("f_k2", vk(2), 7'd64);
      check("f_on", voice_on, 4'b1111);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
